// File: rtl/stream_dac_pkg.sv
// Shared types and constants for the stream_dac playback engine.
//   fetch_state_e : fetch FSM states
//   UNITY_GAIN    : gain code for 1.0 in unsigned Q1.7
//   idx_width()   : width of the byte index within one frame
package stream_dac_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StFetch,
        StCapture,
        StFull
    } fetch_state_e;

    localparam int unsigned UNITY_GAIN = 128;

    function automatic int unsigned idx_width(input int unsigned frame_bytes);
        return (frame_bytes > 1) ? $clog2(frame_bytes) : 1;
    endfunction

endpackage

// File: rtl/stream_dac_if.sv
// Read side of the SD read FIFO.
//   fifo_rd    : read strobe, data valid the cycle after
//   fifo_empty : FIFO has no data
//   fifo_data  : read data byte
// master = playback engine, slave = FIFO.
interface stream_dac_if;
    logic       fifo_rd;
    logic       fifo_empty;
    logic [7:0] fifo_data;

    modport master (output fifo_rd, input fifo_empty, input fifo_data);
    modport slave  (input fifo_rd, output fifo_empty, output fifo_data);
endinterface

// File: rtl/stream_dac_chan.sv
// One output channel: registered gain/saturate stage feeding a 1-bit modulator.
//   clk, rstn : clock, synchronous active-low reset
//   enable    : playback enable; low clears the active sample (midscale)
//   load      : take a new sample through the gain stage
//   gain      : unsigned Q1.7 gain
//   sample    : signed PCM sample from the pending frame
//   pwm_cnt   : shared PWM counter; pwm_wrap is high when it is about to wrap to 0
//   analog    : registered 1-bit modulator output
// Define STREAM_DAC_SDM_EN to replace PWM with a first-order delta-sigma modulator.
module stream_dac_chan #(
    parameter int unsigned SAMPLE_BITS = 16,
    parameter int unsigned PWM_BITS    = 8
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   enable,
    input  logic                   load,
    input  logic [7:0]             gain,
    input  logic [SAMPLE_BITS-1:0] sample,
    input  logic [PWM_BITS-1:0]    pwm_cnt,
    input  logic                   pwm_wrap,
    output logic                   analog
);
    localparam int unsigned ProdW = SAMPLE_BITS + 9;
    localparam logic signed [ProdW-1:0] SatMax = {{10{1'b0}}, {(SAMPLE_BITS-1){1'b1}}};
    localparam logic signed [ProdW-1:0] SatMin = {{10{1'b1}}, {(SAMPLE_BITS-1){1'b0}}};

    logic signed [ProdW-1:0]   prod;
    logic signed [ProdW-1:0]   scaled;
    logic [SAMPLE_BITS-1:0]    sat;
    logic [SAMPLE_BITS-1:0]    active_q;
    logic [SAMPLE_BITS-1:0]    offset;

    assign prod   = ProdW'($signed(sample)) * ProdW'($signed({1'b0, gain}));
    assign scaled = prod >>> 7;

    always_comb begin
        sat = scaled[SAMPLE_BITS-1:0];
        if (scaled > SatMax) begin
            sat = SatMax[SAMPLE_BITS-1:0];
        end else if (scaled < SatMin) begin
            sat = SatMin[SAMPLE_BITS-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn || !enable) begin
            active_q <= '0;
        end else if (load) begin
            active_q <= sat;
        end
    end

    // Offset binary: midscale (0) maps to half duty.
    assign offset = active_q ^ {1'b1, {(SAMPLE_BITS-1){1'b0}}};

`ifdef STREAM_DAC_SDM_EN
    logic [SAMPLE_BITS:0] acc_q;
    logic                 unused_pwm;

    always_ff @(posedge clk) begin
        if (!rstn || !enable) begin
            acc_q <= '0;
        end else begin
            acc_q <= {1'b0, acc_q[SAMPLE_BITS-1:0]} + {1'b0, offset};
        end
    end

    assign analog     = acc_q[SAMPLE_BITS];
    assign unused_pwm = ^{pwm_cnt, pwm_wrap};
`else
    localparam int unsigned DutyShift = SAMPLE_BITS - PWM_BITS;

    logic [SAMPLE_BITS-1:0] duty_full;
    logic [PWM_BITS-1:0]    duty_q;
    logic                   analog_q;
    logic                   unused_duty;

    assign duty_full   = offset >> DutyShift;
    assign unused_duty = ^duty_full;

    // Duty only changes at the period boundary so no pulse is ever truncated.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            duty_q   <= '0;
            analog_q <= 1'b0;
        end else begin
            if (pwm_wrap) begin
                duty_q <= duty_full[PWM_BITS-1:0];
            end
            analog_q <= (pwm_cnt < duty_q);
        end
    end

    assign analog = analog_q;
`endif

endmodule

// File: rtl/stream_dac.sv
// Multi-channel PCM playback engine: fetches interleaved little-endian frames from the
// SD read FIFO, releases one frame per sample period and drives 1-bit outputs.
//   clk, rstn    : clock, synchronous active-low reset
//   enable       : playback enable
//   fifo         : FIFO read port (stream_dac_if.master)
//   gain         : unsigned Q1.7 gain, 128 = unity
//   analog       : one modulator output per channel
//   frame_tick   : one-cycle pulse at each sample-period boundary
//   underrun_cnt : saturating count of periods without a complete frame
//   busy         : fetch FSM not idle
// Define STREAM_DAC_SDM_EN to use delta-sigma modulators instead of PWM.
module stream_dac
    import stream_dac_pkg::*;
#(
    parameter int unsigned CHANNELS    = 2,
    parameter int unsigned SAMPLE_BITS = 16,
    parameter int unsigned SAMPLE_DIV  = 2268,
    parameter int unsigned PWM_BITS    = 8
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                enable,
    stream_dac_if.master        fifo,
    input  logic [7:0]          gain,
    output logic [CHANNELS-1:0] analog,
    output logic                frame_tick,
    output logic [15:0]         underrun_cnt,
    output logic                busy
);
    localparam int unsigned BPS        = SAMPLE_BITS / 8;
    localparam int unsigned FrameBytes = CHANNELS * BPS;
    localparam int unsigned IdxW       = idx_width(FrameBytes);
    localparam int unsigned DivW       = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;

    logic [DivW-1:0]              div_q;
    fetch_state_e                 state_q, state_d;
    logic [IdxW-1:0]              idx_q, idx_d;
    logic [FrameBytes*8-1:0]      pend_q;
    logic [15:0]                  underrun_q;
    logic [PWM_BITS-1:0]          pwm_cnt_q;
    logic                         pwm_wrap;
    logic                         rd;
    logic                         capture;
    logic                         load;

    // Sample-rate divider, held at 0 while disabled.
    assign frame_tick = (div_q == DivW'(SAMPLE_DIV - 1));

    always_ff @(posedge clk) begin
        if (!rstn || !enable || frame_tick) begin
            div_q <= '0;
        end else begin
            div_q <= div_q + 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        rd      = 1'b0;
        capture = 1'b0;
        load    = 1'b0;
        // Dropping enable discards any partial frame and wins over a coincident tick.
        if (!enable) begin
            state_d = StIdle;
            idx_d   = '0;
        end else begin
            case (state_q)
                StIdle: state_d = StFetch;
                StFetch: begin
                    if (!fifo.fifo_empty) begin
                        rd      = 1'b1;
                        state_d = StCapture;
                    end
                end
                StCapture: begin
                    capture = 1'b1;
                    if (idx_q == IdxW'(FrameBytes - 1)) begin
                        idx_d   = '0;
                        state_d = StFull;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = StFetch;
                    end
                end
                StFull: begin
                    if (frame_tick) begin
                        load    = 1'b1;
                        state_d = StFetch;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= StIdle;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            pend_q <= '0;
        end else if (capture) begin
            pend_q[idx_q*8 +: 8] <= fifo.fifo_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            underrun_q <= '0;
        end else if (enable && frame_tick && (state_q != StFull) && (underrun_q != 16'hFFFF)) begin
            underrun_q <= underrun_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            pwm_cnt_q <= '0;
        end else begin
            pwm_cnt_q <= pwm_cnt_q + 1'b1;
        end
    end

    assign pwm_wrap     = &pwm_cnt_q;
    assign fifo.fifo_rd = rd;
    assign underrun_cnt = underrun_q;
    assign busy         = (state_q != StIdle);

    for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
        stream_dac_chan #(
            .SAMPLE_BITS (SAMPLE_BITS),
            .PWM_BITS    (PWM_BITS)
        ) u_chan (
            .clk      (clk),
            .rstn     (rstn),
            .enable   (enable),
            .load     (load),
            .gain     (gain),
            .sample   (pend_q[c*SAMPLE_BITS +: SAMPLE_BITS]),
            .pwm_cnt  (pwm_cnt_q),
            .pwm_wrap (pwm_wrap),
            .analog   (analog[c])
        );
    end

endmodule
